// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the memory stage: memory-op codes, MEM FSM states,
// and helpers that classify an op by byte count and direction.
package riscv_pkg;

  localparam logic [3:0] MOP_NONE = 4'd0;
  localparam logic [3:0] MOP_LB   = 4'd1;
  localparam logic [3:0] MOP_LH   = 4'd2;
  localparam logic [3:0] MOP_LW   = 4'd3;
  localparam logic [3:0] MOP_LBU  = 4'd4;
  localparam logic [3:0] MOP_LHU  = 4'd5;
  localparam logic [3:0] MOP_SB   = 4'd6;
  localparam logic [3:0] MOP_SH   = 4'd7;
  localparam logic [3:0] MOP_SW   = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RDW  = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  // Zero for NONE and the reserved codes, which makes "is a memory op" a nonzero test.
  function automatic logic [2:0] mop_bytes(input logic [3:0] mop);
    case (mop)
      MOP_LB, MOP_LBU, MOP_SB: mop_bytes = 3'd1;
      MOP_LH, MOP_LHU, MOP_SH: mop_bytes = 3'd2;
      MOP_LW, MOP_SW:          mop_bytes = 3'd4;
      default:                 mop_bytes = 3'd0;
    endcase
  endfunction

  function automatic logic mop_is_store(input logic [3:0] mop);
    mop_is_store = (mop == MOP_SB) || (mop == MOP_SH) || (mop == MOP_SW);
  endfunction

endpackage

// File: rtl/mem_ldext.sv
// Load-result extension: picks the loaded width out of the assembled word and
// sign- or zero-extends it to 32 bits.
module mem_ldext (
  input  logic [3:0]  mop,
  input  logic [31:0] word,
  output logic [31:0] result
);
  import riscv_pkg::*;

  always_comb begin
    case (mop)
      MOP_LB:  result = {{24{word[7]}}, word[7:0]};
      MOP_LH:  result = {{16{word[15]}}, word[15:0]};
      MOP_LBU: result = {24'b0, word[7:0]};
      MOP_LHU: result = {16'b0, word[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: pass-through for non-memory ops, byte-serial load/store FSM otherwise.
// Optional alignment trap enabled by defining MEM_ALIGN_CHECK_EN (adds the misalign port).
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mm_wa,
  input  logic        mm_we,
  input  logic [31:0] mm_wn,
  input  logic [3:0]  mm_mop,
  input  logic [31:0] mm_sd,
  output logic [4:0]  wb_wa,
  output logic        wb_we,
  output logic [31:0] wb_wn,
  output logic        stall_req,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_a,
  output logic [7:0]  mem_dout,
  input  logic        mem_gnt,
  input  logic [7:0]  mem_din
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        misalign
`endif
);
  import riscv_pkg::*;

  mem_state_e  state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] asm_q, asm_d;
  logic [2:0]  nbytes;
  logic        is_mem, is_store, last, bad_align;
  logic [31:0] ld_val;

  assign nbytes   = mop_bytes(mm_mop);
  assign is_mem   = (nbytes != 3'd0);
  assign is_store = mop_is_store(mm_mop);
  assign last     = ({1'b0, k_q} == (nbytes - 3'd1));

`ifdef MEM_ALIGN_CHECK_EN
  assign bad_align = ((nbytes == 3'd2) && mm_wn[0]) ||
                     ((nbytes == 3'd4) && (mm_wn[1:0] != 2'b00));
`else
  assign bad_align = 1'b0;
`endif

  mem_ldext u_ldext (
    .mop    (mm_mop),
    .word   (asm_q),
    .result (ld_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
      asm_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      asm_q   <= asm_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    asm_d     = asm_q;
    wb_wa     = mm_wa;
    wb_we     = mm_we;
    wb_wn     = mm_wn;
    stall_req = 1'b0;
    mem_req   = 1'b0;
    mem_wr    = is_store;
    mem_a     = mm_wn + {30'b0, k_q};
    mem_dout  = mm_sd[{k_q, 3'b000} +: 8];
`ifdef MEM_ALIGN_CHECK_EN
    misalign  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        k_d   = 2'd0;
        asm_d = 32'd0;
        if (is_mem) begin
          stall_req = 1'b1;
          wb_we     = 1'b0;
          state_d   = bad_align ? DONE : REQ;
        end
      end
      REQ: begin
        stall_req = 1'b1;
        wb_we     = 1'b0;
        mem_req   = 1'b1;
        if (mem_gnt) begin
          if (is_store) begin
            k_d     = k_q + 2'd1;
            state_d = last ? DONE : REQ;
          end else begin
            state_d = RDW;
          end
        end
      end
      RDW: begin
        stall_req = 1'b1;
        wb_we     = 1'b0;
        asm_d[{k_q, 3'b000} +: 8] = mem_din;
        k_d       = k_q + 2'd1;
        state_d   = last ? DONE : REQ;
      end
      DONE: begin
        state_d = IDLE;
        // The op retires here; mm_* is still held, so misalignment is re-derived rather than stored.
        if (is_store || bad_align) begin
          wb_we = 1'b0;
        end else begin
          wb_wn = ld_val;
        end
`ifdef MEM_ALIGN_CHECK_EN
        misalign = bad_align;
`endif
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      wb_wa     = 5'd0;
      wb_we     = 1'b0;
      wb_wn     = 32'd0;
      stall_req = 1'b0;
      mem_req   = 1'b0;
      mem_wr    = 1'b0;
      mem_a     = 32'd0;
      mem_dout  = 8'd0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign  = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized ops checked against a
// timeline/byte-array reference model and a responding byte memory.
module tb_mem_stage;
  localparam logic [3:0] NONE = 4'd0, LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4,
                         LHU = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mm_wa;
  logic        mm_we;
  logic [31:0] mm_wn;
  logic [3:0]  mm_mop;
  logic [31:0] mm_sd;
  logic [4:0]  wb_wa;
  logic        wb_we;
  logic [31:0] wb_wn;
  logic        stall_req, mem_req, mem_wr, mem_gnt;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout, mem_din;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic       gpat [0:63];
  logic [7:0] dut_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .mm_wa(mm_wa), .mm_we(mm_we), .mm_wn(mm_wn), .mm_mop(mm_mop), .mm_sd(mm_sd),
    .wb_wa(wb_wa), .wb_we(wb_we), .wb_wn(wb_wn), .stall_req(stall_req),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_a(mem_a), .mem_dout(mem_dout),
    .mem_gnt(mem_gnt), .mem_din(mem_din)
`ifdef MEM_ALIGN_CHECK_EN
    , .misalign(misalign)
`endif
  );

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] dut_rd(input logic [31:0] a);
    return dut_mem.exists(a) ? dut_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    dut_mem[a] = d;
    ref_mem[a] = d;
  endtask

  task automatic gnt_all_ones();
    for (int i = 0; i < 64; i++) gpat[i] = 1'b1;
  endtask

  // Runs one op starting at a negedge in IDLE, acting as the memory, and checks it
  // against the reference model. Returns on the negedge after the retiring cycle.
  task automatic run_op(input logic [3:0] mop, input logic [31:0] addr, input logic [31:0] sd,
                        input logic [4:0] wa, input logic we,
                        output int cyc, output logic [31:0] o_wn, output logic o_we);
    int n, t, exp_cyc;
    logic is_ld, is_st, mis, partial, pend, fin, o_mis, exp_we;
    logic [31:0] exp_a[$];
    logic [31:0] got_a[$];
    logic [31:0] pend_a, v, exp_wn;
    logic [4:0]  o_wa;

    n = (mop == LB || mop == LBU || mop == SB) ? 1 :
        (mop == LH || mop == LHU || mop == SH) ? 2 :
        (mop == LW || mop == SW) ? 4 : 0;
    is_st = (mop == SB || mop == SH || mop == SW);
    is_ld = (n != 0) && !is_st;
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
`endif
    v = 32'd0;
    if (n == 0) exp_cyc = 1;
    else if (mis) exp_cyc = 2;
    else begin
      t = 1;
      for (int i = 0; i < n; i++) begin
        while (!gpat[t]) t++;
        exp_a.push_back(addr + 32'(i));
        t++;
        if (is_ld) begin
          t++;
          v = v | (32'(ref_rd(addr + 32'(i))) << (8 * i));
        end else begin
          ref_mem[addr + 32'(i)] = sd[8*i +: 8];
        end
      end
      exp_cyc = t + 1;
    end
    case (mop)
      LB:      exp_wn = 32'($signed(v[7:0]));
      LH:      exp_wn = 32'($signed(v[15:0]));
      LBU, LHU, LW: exp_wn = v;
      default: exp_wn = addr;
    endcase
    exp_we = (n == 0) ? we : (is_ld && !mis) ? we : 1'b0;

    mm_mop = mop; mm_wn = addr; mm_sd = sd; mm_wa = wa; mm_we = we;
    cyc = 0; pend = 0; partial = 0; fin = 0; o_mis = 0;
    o_wn = 32'd0; o_we = 1'b0; o_wa = 5'd0;
    while (!fin && cyc < 200) begin
      if (pend) begin
        mem_din = dut_rd(pend_a);
        pend = 0;
      end else begin
        mem_din = 8'($urandom);
      end
      mem_gnt = (cyc < 64) ? gpat[cyc] : 1'b1;
      #1;
      cyc++;
      if (stall_req && wb_we) partial = 1'b1;
      if (mem_req && mem_gnt) begin
        got_a.push_back(mem_a);
        if (mem_wr) dut_mem[mem_a] = mem_dout;
        else begin pend = 1'b1; pend_a = mem_a; end
      end
      if (!stall_req) begin
        fin = 1'b1;
        o_wn = wb_wn; o_we = wb_we; o_wa = wb_wa;
`ifdef MEM_ALIGN_CHECK_EN
        o_mis = misalign;
`endif
      end
      @(negedge clk);
    end
    mem_gnt = 1'b0;

    n_checks++;
    if (cyc !== exp_cyc) begin
      n_fail++; $display("FAIL latency mop=%0d addr=%h: got %0d cycles, expected %0d", mop, addr, cyc, exp_cyc);
    end
    n_checks++;
    if (got_a.size() !== exp_a.size()) begin
      n_fail++; $display("FAIL req_count mop=%0d addr=%h: got %0d, expected %0d", mop, addr, got_a.size(), exp_a.size());
    end
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
      n_checks++;
      if (got_a[i] !== exp_a[i]) begin
        n_fail++; $display("FAIL req_addr[%0d] mop=%0d: got %h, expected %h", i, mop, got_a[i], exp_a[i]);
      end
    end
    n_checks++;
    if (partial !== 1'b0) begin
      n_fail++; $display("FAIL partial_wb mop=%0d addr=%h: wb_we seen high while stalled", mop, addr);
    end
    n_checks++;
    if (o_we !== exp_we) begin
      n_fail++; $display("FAIL wb_we mop=%0d addr=%h: got %b, expected %b", mop, addr, o_we, exp_we);
    end
    if (n == 0 || (is_ld && !mis)) begin
      n_checks++;
      if (o_wn !== exp_wn || o_wa !== wa) begin
        n_fail++; $display("FAIL wb_data mop=%0d addr=%h: got wa=%0d wn=%h, expected wa=%0d wn=%h", mop, addr, o_wa, o_wn, wa, exp_wn);
      end
    end
    if (is_st && !mis) begin
      for (int i = 0; i < n; i++) begin
        n_checks++;
        if (dut_rd(addr + 32'(i)) !== ref_rd(addr + 32'(i))) begin
          n_fail++; $display("FAIL store_byte addr=%h: got %h, expected %h", addr + 32'(i), dut_rd(addr + 32'(i)), ref_rd(addr + 32'(i)));
        end
      end
    end
`ifdef MEM_ALIGN_CHECK_EN
    n_checks++;
    if (o_mis !== mis) begin
      n_fail++; $display("FAIL misalign mop=%0d addr=%h: got %b, expected %b", mop, addr, o_mis, mis);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mm_mop = LW; mm_wn = 32'h100; mm_wa = 5'd3; mm_we = 1'b1; mm_sd = 32'hFFFF_FFFF;
    mem_gnt = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({wb_wa, wb_we, wb_wn, stall_req, mem_req, mem_wr, mem_a, mem_dout} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got stall=%b req=%b wb_we=%b wn=%h, expected all zero", stall_req, mem_req, wb_we, wb_wn);
    end
    @(negedge clk);
    rst = 1'b0; mm_mop = NONE; mem_gnt = 1'b0;
  endtask

  task automatic test_passthrough();
    int c; logic [31:0] wn; logic we;
    mm_mop = NONE; mm_wa = 5'd5; mm_we = 1'b1; mm_wn = 32'h1234; mm_sd = 32'd0;
    #1;
    n_checks++;
    if (wb_wa !== 5'd5 || wb_we !== 1'b1 || wb_wn !== 32'h1234 || stall_req !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL passthrough: got wa=%0d we=%b wn=%h stall=%b req=%b, expected 5 1 00001234 0 0", wb_wa, wb_we, wb_wn, stall_req, mem_req);
    end
    run_op(NONE, 32'h1234, 32'd0, 5'd5, 1'b1, c, wn, we);
    run_op(4'd12, 32'hDEAD_BEEF, 32'd0, 5'd9, 1'b1, c, wn, we);
  endtask

  task automatic test_lw();
    int c; logic [31:0] wn; logic we;
    gnt_all_ones();
    preload(32'h100, 8'h78); preload(32'h101, 8'h56);
    preload(32'h102, 8'h34); preload(32'h103, 8'h12);
    run_op(LW, 32'h100, 32'd0, 5'd7, 1'b1, c, wn, we);
    n_checks++;
    if (c !== 10 || wn !== 32'h1234_5678) begin
      n_fail++; $display("FAIL lw_directed: got %0d cycles wn=%h, expected 10 cycles wn=12345678", c, wn);
    end
  endtask

  task automatic test_lb_lbu();
    int c; logic [31:0] wn; logic we;
    gnt_all_ones();
    preload(32'h300, 8'h80);
    run_op(LB, 32'h300, 32'd0, 5'd1, 1'b1, c, wn, we);
    n_checks++;
    if (wn !== 32'hFFFF_FF80) begin
      n_fail++; $display("FAIL lb_sign: got %h, expected ffffff80", wn);
    end
    run_op(LBU, 32'h300, 32'd0, 5'd1, 1'b1, c, wn, we);
    n_checks++;
    if (wn !== 32'h0000_0080) begin
      n_fail++; $display("FAIL lbu_zero: got %h, expected 00000080", wn);
    end
  endtask

  task automatic test_sh_stall();
    int c; logic [31:0] wn; logic we;
    gnt_all_ones();
    gpat[1] = 1'b0; gpat[2] = 1'b0; gpat[4] = 1'b0; gpat[5] = 1'b0;
    run_op(SH, 32'h200, 32'hAABB_CCDD, 5'd2, 1'b1, c, wn, we);
    n_checks++;
    if (dut_rd(32'h200) !== 8'hDD || dut_rd(32'h201) !== 8'hCC || we !== 1'b0 || c !== 8) begin
      n_fail++; $display("FAIL sh_stall: got %h,%h we=%b %0d cycles, expected dd,cc we=0 8 cycles", dut_rd(32'h200), dut_rd(32'h201), we, c);
    end
    gnt_all_ones();
  endtask

  task automatic test_wrap();
    int c; logic [31:0] wn; logic we;
    gnt_all_ones();
    preload(32'hFFFF_FFFF, 8'h34); preload(32'h0000_0000, 8'h92);
    run_op(LH, 32'hFFFF_FFFF, 32'd0, 5'd4, 1'b1, c, wn, we);
    n_checks++;
`ifdef MEM_ALIGN_CHECK_EN
    if (c !== 2 || we !== 1'b0) begin
      n_fail++; $display("FAIL wrap_misalign: got %0d cycles we=%b, expected 2 cycles we=0", c, we);
    end
`else
    if (c !== 6 || wn !== 32'hFFFF_9234) begin
      n_fail++; $display("FAIL wrap_lh: got %0d cycles wn=%h, expected 6 cycles ffff9234", c, wn);
    end
`endif
  endtask

  task automatic test_reset_mid_lw();
    int c; logic [31:0] wn; logic we;
    gnt_all_ones();
    mm_mop = LW; mm_wn = 32'h400; mm_wa = 5'd6; mm_we = 1'b1; mm_sd = 32'd0;
    mem_gnt = 1'b1;
    repeat (4) begin
      mem_din = 8'($urandom);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || stall_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_abort: got req=%b stall=%b, expected 0 0", mem_req, stall_req);
    end
    @(negedge clk);
    rst = 1'b0; mem_gnt = 1'b0;
    #1;
    n_checks++;
    if (stall_req !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: got stall=%b req=%b, expected 1 0", stall_req, mem_req);
    end
    run_op(LW, 32'h400, 32'd0, 5'd6, 1'b1, c, wn, we);
  endtask

  task automatic test_back_to_back();
    int c; logic [31:0] wn, d; logic we;
    gnt_all_ones();
    d = $urandom;
    run_op(SW, 32'h500, d, 5'd8, 1'b1, c, wn, we);
    run_op(LW, 32'h500, 32'd0, 5'd8, 1'b1, c, wn, we);
    n_checks++;
    if (wn !== d) begin
      n_fail++; $display("FAIL sw_lw_roundtrip: got %h, expected %h", wn, d);
    end
  endtask

  task automatic test_random();
    int c; logic [31:0] wn, a; logic we;
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 64; i++) gpat[i] = (i >= 40) ? 1'b1 : ($urandom_range(0, 9) < 6);
      a = ($urandom_range(0, 3) == 0) ? $urandom : (32'h800 + 32'($urandom_range(0, 15)));
      run_op(4'($urandom_range(0, 15)), a, $urandom, 5'($urandom), 1'($urandom), c, wn, we);
    end
  endtask

  initial begin
    rst = 1'b1; mm_wa = '0; mm_we = 1'b0; mm_wn = '0; mm_mop = NONE; mm_sd = '0;
    mem_gnt = 1'b0; mem_din = '0;
    gnt_all_ones();
    @(negedge clk);
    test_reset();
    test_passthrough();
    test_lw();
    test_lb_lbu();
    test_sh_stall();
    test_wrap();
    test_reset_mid_lw();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
